// File: rtl/hog_pkg.sv
// -----------------------------------------------------------------------------
// hog_pkg
// Shared definitions for the HOG gradient front end: default pixel, gradient
// and magnitude widths, plus a constant-evaluable clog2 used to size the
// coordinate ports.
// -----------------------------------------------------------------------------
package hog_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int GRAD_WIDTH_DEFAULT = DATA_WIDTH_DEFAULT + 1;
    localparam int MAG_WIDTH_DEFAULT  = DATA_WIDTH_DEFAULT + 2;

    // Bits needed to hold the values 0..value-1. Never returns 0, so a
    // degenerate one-entry range still yields a legal 1-bit vector.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/grad_core.sv
// -----------------------------------------------------------------------------
// grad_core
// Purely combinational centred-difference gradient of the 4-pixel centre cross.
//
// Ports:
//   pix_right  in   DATA_WIDTH  P(1,0), newest column of the centre row
//   pix_left   in   DATA_WIDTH  P(1,2), oldest column of the centre row
//   pix_bottom in   DATA_WIDTH  P(0,1), newest row of the centre column
//   pix_top    in   DATA_WIDTH  P(2,1), oldest row of the centre column
//   gx         out  GRAD_WIDTH  signed right - left
//   gy         out  GRAD_WIDTH  signed bottom - top
//   mag        out  MAG_WIDTH   |gx| + |gy|
// -----------------------------------------------------------------------------
module grad_core
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int GRAD_WIDTH = DATA_WIDTH + 1,
    parameter int MAG_WIDTH  = DATA_WIDTH + 2
) (
    input  logic        [DATA_WIDTH-1:0] pix_right,
    input  logic        [DATA_WIDTH-1:0] pix_left,
    input  logic        [DATA_WIDTH-1:0] pix_bottom,
    input  logic        [DATA_WIDTH-1:0] pix_top,
    output logic signed [GRAD_WIDTH-1:0] gx,
    output logic signed [GRAD_WIDTH-1:0] gy,
    output logic        [MAG_WIDTH-1:0]  mag
);

    logic [GRAD_WIDTH-1:0] abs_gx;
    logic [GRAD_WIDTH-1:0] abs_gy;

    // Operands are zero-extended by one bit first, so the difference of two
    // unsigned pixels always fits the signed result without wrapping.
    assign gx = GRAD_WIDTH'(pix_right)  - GRAD_WIDTH'(pix_left);
    assign gy = GRAD_WIDTH'(pix_bottom) - GRAD_WIDTH'(pix_top);

    // The most negative difference is -(2^DATA_WIDTH - 1), so negation never
    // overflows GRAD_WIDTH bits.
    assign abs_gx = gx[GRAD_WIDTH-1] ? $unsigned(-gx) : $unsigned(gx);
    assign abs_gy = gy[GRAD_WIDTH-1] ? $unsigned(-gy) : $unsigned(gy);

    // One extra bit absorbs the carry of the sum; no saturation needed.
    assign mag = MAG_WIDTH'(abs_gx) + MAG_WIDTH'(abs_gy);

endmodule

// File: rtl/kernel_grad.sv
// -----------------------------------------------------------------------------
// kernel_grad
// Consumes 3x3 windows from the line buffer, drops windows that straddle a row
// wrap, and emits HOG centred-difference gradients with output coordinates on a
// two-stage valid/ready pipeline (S1: centre cross + coordinates, S2: results).
//
// Ports:
//   clk       in   1                 clock
//   rst       in   1                 synchronous active-high reset
//   kernel    in   9*DATA_WIDTH      window, P(r,c) at [(r*3+c)*DATA_WIDTH +: DATA_WIDTH]
//   k_valid   in   1                 window valid
//   k_border  in   1                 window straddles a row wrap; consume and discard
//   k_ready   out  1                 window accepted when k_valid && k_ready
//   g_valid   out  1                 gradient output valid
//   g_ready   in   1                 downstream ready
//   gx, gy    out  GRAD_WIDTH        signed gradients
//   mag       out  MAG_WIDTH         |gx| + |gy|
//   g_col     out  clog2(IMG_WIDTH)  output column 0..IMG_WIDTH-3
//   g_row     out  clog2(IMG_HEIGHT) output row 0..IMG_HEIGHT-3
//   g_eol     out  1                 last column of an output row
//   g_eof     out  1                 last output of the frame
// -----------------------------------------------------------------------------
module kernel_grad
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int IMG_WIDTH  = 854,
    parameter int IMG_HEIGHT = 480,
    parameter int GRAD_WIDTH = DATA_WIDTH + 1,
    parameter int MAG_WIDTH  = DATA_WIDTH + 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic        [9*DATA_WIDTH-1:0]     kernel,
    input  logic                               k_valid,
    input  logic                               k_border,
    output logic                               k_ready,
    output logic                               g_valid,
    input  logic                               g_ready,
    output logic signed [GRAD_WIDTH-1:0]       gx,
    output logic signed [GRAD_WIDTH-1:0]       gy,
    output logic        [MAG_WIDTH-1:0]        mag,
    output logic        [clog2(IMG_WIDTH)-1:0] g_col,
    output logic        [clog2(IMG_HEIGHT)-1:0] g_row,
    output logic                               g_eol,
    output logic                               g_eof
);

    localparam int COL_WIDTH = clog2(IMG_WIDTH);
    localparam int ROW_WIDTH = clog2(IMG_HEIGHT);

    // A 3x3 window yields IMG_WIDTH-2 columns and IMG_HEIGHT-2 rows of output.
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 3);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(IMG_HEIGHT - 3);

    // Centre-cross taps: c=0 is the right (newest) column, r=0 the bottom row.
    logic [DATA_WIDTH-1:0] in_right;
    logic [DATA_WIDTH-1:0] in_left;
    logic [DATA_WIDTH-1:0] in_bottom;
    logic [DATA_WIDTH-1:0] in_top;

    assign in_right  = kernel[(1*3+0)*DATA_WIDTH +: DATA_WIDTH];
    assign in_left   = kernel[(1*3+2)*DATA_WIDTH +: DATA_WIDTH];
    assign in_bottom = kernel[(0*3+1)*DATA_WIDTH +: DATA_WIDTH];
    assign in_top    = kernel[(2*3+1)*DATA_WIDTH +: DATA_WIDTH];

    // ---------------------------------------------------------------- handshake
    logic s1_valid;
    logic s2_adv;
    logic s1_adv;
    logic accept;
    logic take;

    assign s2_adv  = !g_valid || g_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign k_ready = s1_adv;
    assign accept  = k_valid && k_ready;
    // Border windows are handshaken away but never enter the pipeline.
    assign take    = accept && !k_border;

    // ----------------------------------------------------- coordinate counters
    logic [COL_WIDTH-1:0] col_cnt;
    logic [ROW_WIDTH-1:0] row_cnt;
    logic [COL_WIDTH-1:0] col_next;
    logic [ROW_WIDTH-1:0] row_next;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        col_next = col_cnt + COL_WIDTH'(1);
        row_next = row_cnt;
        if (col_cnt == COL_LAST) begin
            col_next = '0;
            row_next = (row_cnt == ROW_LAST) ? '0 : row_cnt + ROW_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (take) begin
            col_cnt <= col_next;
            row_cnt <= row_next;
        end
    end

    // ------------------------------------------------------------------ stage 1
    logic [DATA_WIDTH-1:0] s1_right;
    logic [DATA_WIDTH-1:0] s1_left;
    logic [DATA_WIDTH-1:0] s1_bottom;
    logic [DATA_WIDTH-1:0] s1_top;
    logic [COL_WIDTH-1:0]  s1_col;
    logic [ROW_WIDTH-1:0]  s1_row;

    // NOTE: the data registers are reset along with the valids because the
    // outputs are defined to read zero out of reset, not just be ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_right  <= '0;
            s1_left   <= '0;
            s1_bottom <= '0;
            s1_top    <= '0;
            s1_col    <= '0;
            s1_row    <= '0;
        end else if (s1_adv) begin
            // A border window (or no window) empties S1 if it was advancing.
            s1_valid <= take;
            if (take) begin
                s1_right  <= in_right;
                s1_left   <= in_left;
                s1_bottom <= in_bottom;
                s1_top    <= in_top;
                s1_col    <= col_cnt;
                s1_row    <= row_cnt;
            end
        end
    end

    // --------------------------------------------------------- gradient core
    logic signed [GRAD_WIDTH-1:0] core_gx;
    logic signed [GRAD_WIDTH-1:0] core_gy;
    logic        [MAG_WIDTH-1:0]  core_mag;

    grad_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .GRAD_WIDTH (GRAD_WIDTH),
        .MAG_WIDTH  (MAG_WIDTH)
    ) u_grad_core (
        .pix_right  (s1_right),
        .pix_left   (s1_left),
        .pix_bottom (s1_bottom),
        .pix_top    (s1_top),
        .gx         (core_gx),
        .gy         (core_gy),
        .mag        (core_mag)
    );

    // ------------------------------------------------------------------ stage 2
    // Outputs only change when S2 advances, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_valid <= 1'b0;
            gx      <= '0;
            gy      <= '0;
            mag     <= '0;
            g_col   <= '0;
            g_row   <= '0;
            g_eol   <= 1'b0;
            g_eof   <= 1'b0;
        end else if (s2_adv) begin
            g_valid <= s1_valid;
            if (s1_valid) begin
                gx    <= core_gx;
                gy    <= core_gy;
                mag   <= core_mag;
                g_col <= s1_col;
                g_row <= s1_row;
                g_eol <= (s1_col == COL_LAST);
                g_eof <= (s1_col == COL_LAST) && (s1_row == ROW_LAST);
            end
        end
    end

endmodule

// File: tb/tb_kernel_grad.sv
// -----------------------------------------------------------------------------
// tb_kernel_grad
// Self-checking bench for kernel_grad on a small 6x5 frame. A reference model
// turns every accepted non-border window into an expected result (pixel
// differences by plain integer arithmetic, coordinates from the running count
// of accepted windows) and compares it with each transferred output in order.
// -----------------------------------------------------------------------------
module tb_kernel_grad;

    localparam int DW = 8;
    localparam int IW = 6;
    localparam int IH = 5;
    localparam int GW = DW + 1;
    localparam int MW = DW + 2;
    localparam int CW = hog_pkg::clog2(IW);
    localparam int RW = hog_pkg::clog2(IH);
    localparam int OUT_COLS = IW - 2;
    localparam int OUT_ROWS = IH - 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [9*DW-1:0]      kernel = '0;
    logic                 k_valid = 1'b0;
    logic                 k_border = 1'b0;
    logic                 k_ready;
    logic                 g_valid;
    logic                 g_ready = 1'b1;
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [MW-1:0]        mag;
    logic [CW-1:0]        g_col;
    logic [RW-1:0]        g_row;
    logic                 g_eol;
    logic                 g_eof;

    kernel_grad #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .GRAD_WIDTH (GW),
        .MAG_WIDTH  (MW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kernel   (kernel),
        .k_valid  (k_valid),
        .k_border (k_border),
        .k_ready  (k_ready),
        .g_valid  (g_valid),
        .g_ready  (g_ready),
        .gx       (gx),
        .gy       (gy),
        .mag      (mag),
        .g_col    (g_col),
        .g_row    (g_row),
        .g_eol    (g_eol),
        .g_eof    (g_eof)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ bookkeeping
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int gx;
        int gy;
        int mag;
        int col;
        int row;
        int eol;
        int eof;
    } result_t;

    result_t expq[$];
    int n_taken   = 0;   // non-border windows accepted since the last reset
    int out_count = 0;
    int eof_count = 0;
    int stall_seen = 0;
    int cyc = 0;

    // ---------------------------------------------------------- ready driver
    int rdy_mode   = 0;  // 0: always ready, 1: random, 2: held low
    int hold_until = 0;  // g_ready forced low while cyc < hold_until

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (cyc < hold_until)   g_ready = 1'b0;
        else if (rdy_mode == 0) g_ready = 1'b1;
        else if (rdy_mode == 1) g_ready = ($urandom_range(0, 2) != 0);
        else                    g_ready = 1'b0;
    end

    // -------------------------------------------------------- reference model
    function automatic int px(input logic [9*DW-1:0] w, input int r, input int c);
        logic [DW-1:0] v;
        v = w[(r*3+c)*DW +: DW];
        return int'(v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic result_t model(input logic [9*DW-1:0] w, input int n);
        result_t e;
        e.gx  = px(w, 1, 0) - px(w, 1, 2);
        e.gy  = px(w, 0, 1) - px(w, 2, 1);
        e.mag = iabs(e.gx) + iabs(e.gy);
        e.col = n % OUT_COLS;
        e.row = (n / OUT_COLS) % OUT_ROWS;
        e.eol = (e.col == OUT_COLS - 1) ? 1 : 0;
        e.eof = (e.eol == 1 && e.row == OUT_ROWS - 1) ? 1 : 0;
        return e;
    endfunction

    // ---------------------------------------------------------------- monitor
    // Sampled on the falling edge: inputs and outputs are stable, and a
    // valid&&ready seen here is the transfer that happens on the next rise.
    logic            have_snap = 1'b0;
    logic [27:0]     snap_data;
    logic [7:0]      snap_meta;

    always @(negedge clk) begin
        if (rst) begin
            have_snap = 1'b0;
        end else begin
            if (have_snap && g_valid) begin
                check("hold_data", int'({gx, gy, mag}), int'(snap_data));
                check("hold_meta", int'({g_col, g_row, g_eol, g_eof}), int'(snap_meta));
            end
            have_snap = g_valid && !g_ready;
            snap_data = {gx, gy, mag};
            snap_meta = 8'({g_col, g_row, g_eol, g_eof});

            if (g_valid && g_ready) begin
                if (expq.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    result_t e;
                    e = expq.pop_front();
                    check("gx",    int'(gx),    e.gx);
                    check("gy",    int'(gy),    e.gy);
                    check("mag",   int'(mag),   e.mag);
                    check("g_col", int'(g_col), e.col);
                    check("g_row", int'(g_row), e.row);
                    check("g_eol", int'(g_eol), e.eol);
                    check("g_eof", int'(g_eof), e.eof);
                end
                out_count++;
                if (g_eof) eof_count++;
            end

            // Input can only stall when both stages hold an undelivered result.
            if (k_valid && !k_ready) begin
                stall_seen++;
                check("stall_inflight", expq.size(), 2);
                check("stall_g_valid", int'(g_valid), 1);
            end

            if (k_valid && k_ready && !k_border) begin
                expq.push_back(model(kernel, n_taken));
                n_taken++;
            end
        end
    end

    // ----------------------------------------------------------------- stimulus
    // All drives happen 1 time unit after the rising edge.
    task automatic send(input logic [9*DW-1:0] w, input logic border);
        logic acc;
        int   budget;
        kernel   = w;
        k_border = border;
        k_valid  = 1'b1;
        budget   = 0;
        do begin
            @(negedge clk);
            acc = k_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!acc && budget < 100);
        if (!acc) check("accept_timeout", 0, 1);
        k_valid  = 1'b0;
        k_border = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((expq.size() != 0 || g_valid) && budget < 300) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_timeout", expq.size(), 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        expq.delete();
        n_taken = 0;
    endtask

    function automatic logic [9*DW-1:0] rand_window();
        logic [9*DW-1:0] w;
        for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'($urandom_range(0, 255));
        return w;
    endfunction

    function automatic logic [9*DW-1:0] cross_window(input int right, input int left,
                                                      input int bottom, input int top);
        logic [9*DW-1:0] w;
        w = rand_window();
        w[(1*3+0)*DW +: DW] = DW'(right);
        w[(1*3+2)*DW +: DW] = DW'(left);
        w[(0*3+1)*DW +: DW] = DW'(bottom);
        w[(2*3+1)*DW +: DW] = DW'(top);
        return w;
    endfunction

    // Sends one window into an empty pipeline and checks latency and result.
    task automatic single(input logic [9*DW-1:0] w, input int egx, input int egy, input int emag);
        int lat;
        send(w, 1'b0);
        lat = 1;
        while (!g_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 2);
        check("dir_gx",  int'(gx),  egx);
        check("dir_gy",  int'(gy),  egy);
        check("dir_mag", int'(mag), emag);
        drain();
    endtask

    int base_out;
    int base_eof;

    initial begin
        // Reset state.
        rst = 1'b1;
        idle(3);
        check("rst_g_valid", int'(g_valid), 0);
        check("rst_k_ready", int'(k_ready), 1);
        check("rst_data",    int'({gx, gy, mag}), 0);
        check("rst_meta",    int'({g_col, g_row, g_eol, g_eof}), 0);
        rst = 1'b0;

        // Directed arithmetic: nominal cross, then the extremes.
        rdy_mode = 0;
        idle(1);
        send(cross_window(200, 50, 10, 90), 1'b0);
        begin
            int lat;
            lat = 1;
            while (!g_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("latency", lat, 2);
            check("t1_gx",    int'(gx),    150);
            check("t1_gy",    int'(gy),    -80);
            check("t1_mag",   int'(mag),   230);
            check("t1_g_col", int'(g_col), 0);
            check("t1_g_row", int'(g_row), 0);
        end
        drain();
        single(cross_window(0, 255, 255, 0), -255, 255, 510);
        single(cross_window(255, 0, 0, 255), 255, -255, 510);

        // Backpressure: g_ready low for 4 cycles while 5 windows stream in.
        hold_until = cyc + 4;
        idle(1);
        stall_seen = 0;
        for (int i = 0; i < 5; i++) send(rand_window(), 1'b0);
        drain();
        check("bp_stalled", int'(stall_seen > 0), 1);

        // Border drop and frame end on the 6x5 frame (4x3 outputs).
        apply_reset();
        base_out = out_count;
        base_eof = eof_count;
        for (int i = 0; i < 4; i++) send(rand_window(), 1'b0);
        send(rand_window(), 1'b1);
        for (int i = 0; i < 4; i++) send(rand_window(), 1'b0);
        drain();
        check("border_outputs", out_count - base_out, 8);
        for (int i = 0; i < 4; i++) send(rand_window(), 1'b0);
        drain();
        check("frame_eof_count", eof_count - base_eof, 1);
        send(rand_window(), 1'b0);  // 13th: model expects (0,0) again
        drain();

        // Reset with both stages full.
        rdy_mode = 2;
        send(rand_window(), 1'b0);
        send(rand_window(), 1'b0);
        check("full_k_ready", int'(k_ready), 0);
        check("full_g_valid", int'(g_valid), 1);
        rst = 1'b1;
        idle(1);
        check("mid_rst_g_valid", int'(g_valid), 0);
        check("mid_rst_k_ready", int'(k_ready), 1);
        rst = 1'b0;
        expq.delete();
        n_taken = 0;
        rdy_mode = 0;
        send(rand_window(), 1'b0);
        drain();

        // Randomized traffic: gaps, borders and random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else send(rand_window(), ($urandom_range(0, 7) == 0));
        end
        rdy_mode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel_grad.md
Name: kernel_grad

Overview:
- Consumer at the kernel end of the line-buffer window stream. Accepts 3x3 pixel windows (kernel, k_valid, k_border) and returns k_ready.
- Drops windows that straddle a row wrap.
- For every valid window, computes the HOG centred-difference gradients gx and gy, plus an L1 magnitude.
- Emits results as a valid/ready gradient stream tagged with output coordinates and end-of-row/end-of-frame flags, for the downstream orientation-binning stage.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- IMG_WIDTH, 854: input frame width in pixels.
- IMG_HEIGHT, 480: input frame height in pixels.
- GRAD_WIDTH, DATA_WIDTH+1: signed gradient width.
- MAG_WIDTH, DATA_WIDTH+2: unsigned magnitude width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- kernel  in  9*DATA_WIDTH  3x3 window.
- k_valid  in  1  window valid.
- k_border  in  1  window straddles a row wrap; consume and discard.
- k_ready  out  1  window accepted when k_valid && k_ready.
- g_valid  out  1  gradient output valid.
- g_ready  in  1  downstream ready.
- gx  out  GRAD_WIDTH  signed horizontal gradient.
- gy  out  GRAD_WIDTH  signed vertical gradient.
- mag  out  MAG_WIDTH  |gx|+|gy|.
- g_col  out  clog2(IMG_WIDTH)  output column, 0..IMG_WIDTH-3.
- g_row  out  clog2(IMG_HEIGHT)  output row, 0..IMG_HEIGHT-3.
- g_eol  out  1  last column of an output row.
- g_eof  out  1  last output of the frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Window layout:
  - Element (r,c) sits at kernel[(r*3+c)*DATA_WIDTH +: DATA_WIDTH].
  - r=0 is the newest (bottom) image row; r=2 is the oldest (top).
  - c=0 is the newest (rightmost) column.
- Arithmetic:
  - gx = P(1,0) - P(1,2), computed as right minus left.
  - gy = P(0,1) - P(2,1), computed as bottom minus top.
  - Both are zero-extended to GRAD_WIDTH before subtraction, so there is no overflow.
  - Range is -255..255 at the default width.
  - mag = |gx| + |gy|, max 510, with no saturation.
- Pipeline:
  - Stage S1 registers the window centre cross and the metadata.
  - Stage S2 registers gx, gy, mag and the flags.
  - Latency from acceptance to g_valid is 2 cycles when there is no backpressure.
- Handshake:
  - s2_adv = !s2_valid || g_ready.
  - s1_adv = !s1_valid || s2_adv.
  - k_ready = s1_adv, and is combinational from g_ready.
  - Full throughput is 1 window per clock.
  - When g_valid=1 and g_ready=0, gx, gy, mag, g_col, g_row, g_eol and g_eof hold stable.
- Border windows:
  - Accepted when k_valid && k_border && k_ready.
  - Produce no output and do not advance the counters.
  - S1 does not load, so s1_valid goes low if S1 was advancing.
- Coordinate counters:
  - Advance on acceptance of a non-border window.
  - col increments and wraps at IMG_WIDTH-3 to 0; on wrap, row increments.
  - row wraps at IMG_HEIGHT-3 to 0, which ends the frame.
  - g_eol = (g_col == IMG_WIDTH-3).
  - g_eof = g_eol && (g_row == IMG_HEIGHT-3).
  - Counters are captured into S1 with the data.
- Simultaneous events: acceptance and output in the same cycle are legal, and the pipeline shifts.
- Reset values:
  - k_ready is combinational and reads 1 while the pipeline is empty after reset.
  - g_valid, gx, gy, mag, g_col, g_row, g_eol, g_eof, the internal valids and the counters are all 0.
- Reset mid-operation: in-flight data is discarded, and counters restart at (0,0) on the next accepted window.
- k_valid low: no state change other than draining.

Decomposition:
- Shared package (hog_pkg): DATA_WIDTH, GRAD_WIDTH and MAG_WIDTH defaults, plus a clog2 function.
- Sub-module grad_core: purely combinational, computing gx, gy and mag from the 4 cross pixels. It is instantiated once between S1 and S2.
- Counters and handshake stay in kernel_grad.

Test Plan:
- Single window, centre cross P(1,0)=200, P(1,2)=50, P(0,1)=10, P(2,1)=90, g_ready=1 -> g_valid exactly 2 cycles after acceptance, gx=150, gy=-80, mag=230, g_col=0, g_row=0.
- Extremes P(1,0)=0, P(1,2)=255, P(0,1)=255, P(2,1)=0 -> gx=-255, gy=255, mag=510, no wrap.
- Backpressure: stream 5 windows, g_ready low for 4 cycles -> k_ready low after 2 held results; outputs stable; no loss or duplication; order preserved.
- Border drop, using IMG_WIDTH=6 and IMG_HEIGHT=5:
  - Stimulus: feed 4 windows, then a k_border window, then 4 more.
  - Required: exactly 8 outputs.
  - g_col sequence is 0..3, 0..3.
  - g_eol is set on the outputs with g_col=3.
  - g_row is 0 then 1.
- Frame end at the same size: 12 non-border windows -> the 12th has g_eof=1 and g_row=2; the 13th returns g_col=0, g_row=0.
- Reset asserted with both stages full -> the next cycle g_valid=0 and k_ready=1; the first new output has coordinates (0,0).
